// File: rtl/apb4_multi_slave_master.sv
// APB4 requester: turns a valid/ready command into an APB4 transfer to one of NUM_SLAVES
// completers chosen by an address field, with decode-error and wait-state timeout paths.
module apb4_multi_slave_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned SEL_LSB    = 12,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                             pclk,
  input  logic                             preset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic                             cmd_write,
  input  logic [DATA_WIDTH-1:0]            cmd_wdata,
  input  logic [STRB_WIDTH-1:0]            cmd_strb,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             rsp_timeout,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  output logic                             pwrite,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic [STRB_WIDTH-1:0]            pstrb,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr
);

  localparam int unsigned IdxW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e                state_q;
  logic [CntW-1:0]       wait_q;
  logic [IdxW-1:0]       cmd_idx;
  logic                  cmd_mapped;
  logic [NUM_SLAVES-1:0] cmd_sel;
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  timeout_hit;

  assign cmd_idx    = cmd_addr[SEL_LSB +: IdxW];
  assign cmd_mapped = 32'(cmd_idx) < NUM_SLAVES;
  assign cmd_ready  = (state_q == StIdle) && !preset;

  // psel holds the one-hot target during a transfer, so it doubles as the response mux select.
  always_comb begin
    cmd_sel   = '0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      cmd_sel[i] = (32'(cmd_idx) == i);
      if (psel[i]) begin
        sel_rdata = sel_rdata | prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign sel_ready   = |(pready & psel);
  assign sel_err     = |(pslverr & psel);
  assign timeout_hit = (TIMEOUT != 0) && (wait_q == CntW'(TIMEOUT));

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      paddr       <= '0;
      psel        <= '0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      pstrb       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            if (cmd_mapped) begin
              paddr   <= cmd_addr;
              pwrite  <= cmd_write;
              pwdata  <= cmd_wdata;
              pstrb   <= cmd_write ? cmd_strb : '0;
              psel    <= cmd_sel;
              wait_q  <= '0;
              state_q <= StSetup;
            end else begin
              rsp_valid   <= 1'b1;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b0;
              rsp_rdata   <= '0;
              state_q     <= StResp;
            end
          end
        end
        StSetup: begin
          penable <= 1'b1;
          state_q <= StAccess;
        end
        StAccess: begin
          // A pready in the same cycle as the timeout wins.
          if (sel_ready) begin
            psel        <= '0;
            penable     <= 1'b0;
            pstrb       <= '0;
            rsp_valid   <= 1'b1;
            rsp_err     <= sel_err;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= (pwrite || sel_err) ? '0 : sel_rdata;
            state_q     <= StResp;
          end else if (timeout_hit) begin
            psel        <= '0;
            penable     <= 1'b0;
            pstrb       <= '0;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
            state_q     <= StResp;
          end else begin
            wait_q <= wait_q + CntW'(1);
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  psel_onehot_a: assert property (@(posedge pclk) disable iff (preset)
    !$isunknown(psel) && $onehot0(psel));

endmodule

// File: tb/tb_apb4_multi_slave_master.sv
// Randomised bench: behavioural APB slaves plus a transaction-level model of the response,
// latency and bus-phase counts expected for each command.
module tb_apb4_multi_slave_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int NS = 5;
  localparam int SL = 12;
  localparam int TO = 4;

  logic pclk = 1'b0;
  logic preset;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic [NS-1:0] psel, pready, pslverr;
  logic penable, pwrite;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic [NS*DW-1:0] prdata;

  int n_tests = 0;
  int n_fail = 0;

  int            wait_cfg [NS];
  logic          err_cfg  [NS];
  logic [DW-1:0] rdata_cfg[NS];
  int            acc_cnt = 0;
  logic [NS-1:0] noise_rdy = '0;
  logic [NS-1:0] noise_err = '0;

  always #5 pclk = ~pclk;

  apb4_multi_slave_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW),
    .NUM_SLAVES(NS), .SEL_LSB(SL), .TIMEOUT(TO)
  ) u_dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // Slave side: the selected slave answers after wait_cfg ACCESS cycles; everyone else is noise.
  always @(posedge pclk) begin
    if (penable && !(|(pready & psel))) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  always @(negedge pclk) begin
    noise_rdy = NS'($urandom);
    noise_err = NS'($urandom);
  end

  always_comb begin
    prdata  = '0;
    pready  = '0;
    pslverr = '0;
    for (int i = 0; i < NS; i++) begin
      prdata[i*DW +: DW] = rdata_cfg[i];
      if (psel[i] && penable && acc_cnt == wait_cfg[i]) begin
        pready[i]  = 1'b1;
        pslverr[i] = err_cfg[i];
      end else if (psel[i] && penable) begin
        pready[i]  = 1'b0;
        pslverr[i] = noise_err[i];
      end else begin
        pready[i]  = noise_rdy[i];
        pslverr[i] = noise_err[i];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic do_xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                         input logic [SW-1:0] st, input int wt, input logic er,
                         input logic [DW-1:0] rd, input int hold);
    int idx, lat, nacc, k, sel_cyc, en_cyc;
    logic mapped, e_err, e_to;
    logic [DW-1:0] e_rd;
    logic [NS-1:0] e_sel;
    idx    = int'(addr[SL +: 3]);
    mapped = idx < NS;
    e_sel  = '0;
    for (int i = 0; i < NS; i++) rdata_cfg[i] = $urandom;
    if (mapped) begin
      wait_cfg[idx]  = wt;
      err_cfg[idx]   = er;
      rdata_cfg[idx] = rd;
      e_sel[idx]     = 1'b1;
    end
    if (!mapped) begin
      lat = 1; nacc = 0; e_err = 1'b1; e_to = 1'b0; e_rd = '0;
    end else if (wt <= TO) begin
      lat = 3 + wt; nacc = wt + 1; e_err = er; e_to = 1'b0; e_rd = (wr || er) ? '0 : rd;
    end else begin
      lat = 3 + TO; nacc = TO + 1; e_err = 1'b1; e_to = 1'b1; e_rd = '0;
    end

    @(negedge pclk);
    check_eq("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_write = wr;
    cmd_wdata = wd;
    cmd_strb  = st;
    k = 0; sel_cyc = 0; en_cyc = 0;
    do begin
      @(negedge pclk);
      cmd_valid = 1'b0;
      k++;
      check_eq("cmd_ready_busy", 64'(cmd_ready), 64'd0);
      if (psel != '0) begin
        sel_cyc++;
        if (penable) en_cyc++;
        check_eq("psel", 64'(psel), 64'(e_sel));
        check_eq("paddr", 64'(paddr), 64'(addr));
        check_eq("pwrite", 64'(pwrite), 64'(wr));
        check_eq("pwdata", 64'(pwdata), 64'(wd));
        check_eq("pstrb", 64'(pstrb), wr ? 64'(st) : 64'd0);
      end else begin
        check_eq("penable_idle", 64'(penable), 64'd0);
        check_eq("pstrb_idle", 64'(pstrb), 64'd0);
      end
    end while (!rsp_valid && k < 40);
    check_eq("rsp_latency", 64'(k), 64'(lat));
    check_eq("psel_cycles", 64'(sel_cyc), mapped ? 64'(nacc + 1) : 64'd0);
    check_eq("penable_cycles", 64'(en_cyc), 64'(nacc));
    check_eq("rsp_rdata", 64'(rsp_rdata), 64'(e_rd));
    check_eq("rsp_err", 64'(rsp_err), 64'(e_err));
    check_eq("rsp_timeout", 64'(rsp_timeout), 64'(e_to));
    for (int h = 0; h < hold; h++) begin
      @(negedge pclk);
      check_eq("hold_valid", 64'(rsp_valid), 64'd1);
      check_eq("hold_rdata", 64'(rsp_rdata), 64'(e_rd));
      check_eq("hold_err", 64'(rsp_err), 64'(e_err));
      check_eq("hold_timeout", 64'(rsp_timeout), 64'(e_to));
      check_eq("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      check_eq("hold_psel", 64'(psel), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    check_eq("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    check_eq("cmd_ready_after", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    int k;
    preset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_write = 1'b0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NS; i++) begin
      wait_cfg[i]  = 0;
      err_cfg[i]   = 1'b0;
      rdata_cfg[i] = $urandom;
    end
    repeat (3) @(negedge pclk);
    check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check_eq("rst_psel", 64'(psel), 64'd0);
    check_eq("rst_penable", 64'(penable), 64'd0);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_paddr", 64'(paddr), 64'd0);
    check_eq("rst_pstrb", 64'(pstrb), 64'd0);
    check_eq("rst_rsp_err", 64'(rsp_err), 64'd0);
    preset = 1'b0;

    do_xfer(32'h0000_2004, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0, 0);
    do_xfer(32'h0000_1010, 1'b0, 32'h0BAD_F00D, 4'hA, 3, 1'b0, 32'h1234_5678, 0);
    do_xfer(32'h0000_5000, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h5555_AAAA, 0);
    do_xfer(32'h0000_0000, 1'b0, 32'h0, 4'h0, 1000, 1'b0, 32'h1111_2222, 0);
    do_xfer(32'h0000_0000, 1'b0, 32'h0, 4'h0, TO, 1'b0, 32'h3333_4444, 0);
    do_xfer(32'h0000_3000, 1'b0, 32'h0, 4'h0, 0, 1'b1, 32'hCAFE_0001, 4);

    for (int t = 0; t < 40; t++) begin
      logic [AW-1:0] a;
      a = $urandom;
      a[SL +: 3] = 3'($urandom_range(0, 7));
      do_xfer(a, 1'($urandom), $urandom, SW'($urandom), int'($urandom_range(0, 6)),
              1'($urandom_range(0, 3) == 0), $urandom, int'($urandom_range(0, 3)));
    end

    // Reset in the middle of ACCESS on a slave that never answers.
    wait_cfg[1] = 1000;
    @(negedge pclk);
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_1000;
    cmd_write = 1'b0;
    k = 0;
    do begin
      @(negedge pclk);
      cmd_valid = 1'b0;
      k++;
    end while (!penable && k < 10);
    check_eq("pre_reset_access", 64'(penable), 64'd1);
    preset = 1'b1;
    @(negedge pclk);
    check_eq("mid_rst_psel", 64'(psel), 64'd0);
    check_eq("mid_rst_penable", 64'(penable), 64'd0);
    check_eq("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    @(negedge pclk);
    preset = 1'b0;
    #1;
    check_eq("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    do_xfer(32'h0000_4008, 1'b1, 32'hA5A5_5A5A, 4'h3, 2, 1'b0, 32'h0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
